// File: rtl/apb_gpio_if.sv
// APB slave-side bus bundle for the GPIO controller.
interface apb_gpio_if #(
    parameter int unsigned PDATA_SIZE = 32,
    parameter int unsigned PADDR_SIZE = 4
);
    logic                      PSEL;
    logic                      PENABLE;
    logic [PADDR_SIZE-1:0]     PADDR;
    logic                      PWRITE;
    logic [PDATA_SIZE/8-1:0]   PSTRB;
    logic [PDATA_SIZE-1:0]     PWDATA;
    logic [PDATA_SIZE-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_gpio.sv
// APB GPIO controller: MODE/DIRECTION/OUTPUT registers, synchronized INPUT,
// push-pull or open-drain pad drive, zero-wait-state bus.
module apb_gpio #(
    parameter int unsigned PDATA_SIZE = 32,
    parameter int unsigned PADDR_SIZE = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,   // active-high synchronous reset
    apb_gpio_if.slave             apb,
    input  logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] gpio_o,
    output logic [PDATA_SIZE-1:0] gpio_oe
);

    localparam int unsigned NLANES = PDATA_SIZE / 8;

    localparam logic [PADDR_SIZE-1:0] IDX_MODE  = PADDR_SIZE'(0);
    localparam logic [PADDR_SIZE-1:0] IDX_DIR   = PADDR_SIZE'(1);
    localparam logic [PADDR_SIZE-1:0] IDX_OUT   = PADDR_SIZE'(2);
    localparam logic [PADDR_SIZE-1:0] IDX_INPUT = PADDR_SIZE'(3);

    logic [PDATA_SIZE-1:0] mode_q;
    logic [PDATA_SIZE-1:0] dir_q;
    logic [PDATA_SIZE-1:0] out_q;
    logic [PDATA_SIZE-1:0] sync1_q;
    logic [PDATA_SIZE-1:0] sync2_q;

    logic                  access_c;
    logic                  unmapped_c;
    logic                  err_c;
    logic                  wr_c;
    logic [PDATA_SIZE-1:0] wmask_c;
    logic [PDATA_SIZE-1:0] rdata_c;

    // Transfer decode: errors on unmapped indices and writes to the read-only INPUT.
    assign access_c   = apb.PSEL & apb.PENABLE;
    assign unmapped_c = (apb.PADDR > IDX_INPUT);
    assign err_c      = access_c & (unmapped_c | (apb.PWRITE & (apb.PADDR == IDX_INPUT)));
    assign wr_c       = access_c & apb.PWRITE & ~err_c;

    // Expand byte strobes into a per-bit write mask.
    always_comb begin
        wmask_c = '0;
        for (int k = 0; k < NLANES; k++) begin
            wmask_c[8*k +: 8] = {8{apb.PSTRB[k]}};
        end
    end

    // Register file and input synchronizer; reset wins over any concurrent write.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            mode_q  <= '0;
            dir_q   <= '0;
            out_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            if (wr_c) begin
                case (apb.PADDR)
                    IDX_MODE: mode_q <= (mode_q & ~wmask_c) | (apb.PWDATA & wmask_c);
                    IDX_DIR:  dir_q  <= (dir_q  & ~wmask_c) | (apb.PWDATA & wmask_c);
                    IDX_OUT:  out_q  <= (out_q  & ~wmask_c) | (apb.PWDATA & wmask_c);
                    default:  ;
                endcase
            end
        end
    end

    // Combinational read mux; zero whenever no read is selected.
    always_comb begin
        rdata_c = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            case (apb.PADDR)
                IDX_MODE:  rdata_c = mode_q;
                IDX_DIR:   rdata_c = dir_q;
                IDX_OUT:   rdata_c = out_q;
                IDX_INPUT: rdata_c = sync2_q;
                default:   rdata_c = '0;
            endcase
        end
    end

    assign apb.PRDATA  = rdata_c;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = err_c;

    // Open-drain bits only ever pull low: drive enable follows ~OUTPUT, data stays 0.
    assign gpio_o  = out_q & ~mode_q;
    assign gpio_oe = dir_q & ~(mode_q & out_q);

endmodule

// File: tb/tb_apb_gpio.sv
// Directed scoreboard bench for apb_gpio.
module tb_apb_gpio;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [DW-1:0] gpio_i;
    logic [DW-1:0] gpio_o;
    logic [DW-1:0] gpio_oe;

    always #5 PCLK = ~PCLK;

    apb_gpio_if #(.PDATA_SIZE(DW), .PADDR_SIZE(AW)) apb ();

    apb_gpio #(.PDATA_SIZE(DW), .PADDR_SIZE(AW)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (apb),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe)
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Record an expected value at the moment the stimulus is driven.
    task automatic push(input string tag, input logic [DW-1:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Compare the oldest expectation against what the DUT presents now.
    task automatic pop_check(input logic [DW-1:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty observed=0x%h expected=<none>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s observed=0x%h expected=0x%h", e.tag, obs, e.val);
        end
    endtask

    task automatic bus_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PSTRB   = '0;
        apb.PWDATA  = '0;
    endtask

    // Full write transfer; starts one time unit after a rising edge, ends likewise.
    task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW/8-1:0] s, input logic exp_err);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = a;
        apb.PSTRB   = s;
        apb.PWDATA  = d;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        push("wr_pslverr", DW'(exp_err));
        push("wr_pready", DW'(1));
        #1;
        pop_check(DW'(apb.PSLVERR));
        pop_check(DW'(apb.PREADY));
        @(posedge PCLK); #1;
        bus_idle();
    endtask

    // Full read transfer with data/error checked in the access phase.
    task automatic apb_read(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp_d, input logic exp_err);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = a;
        apb.PSTRB   = '0;
        apb.PWDATA  = '0;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        push(tag, exp_d);
        push({tag, "_pslverr"}, DW'(exp_err));
        push({tag, "_pready"}, DW'(1));
        #1;
        pop_check(apb.PRDATA);
        pop_check(DW'(apb.PSLVERR));
        pop_check(DW'(apb.PREADY));
        @(posedge PCLK); #1;
        bus_idle();
    endtask

    // Check current pad outputs against expectations.
    task automatic check_pads(input string tag, input logic [DW-1:0] eo, input logic [DW-1:0] eoe);
        push({tag, "_gpio_o"}, eo);
        push({tag, "_gpio_oe"}, eoe);
        pop_check(gpio_o);
        pop_check(gpio_oe);
    endtask

    initial begin
        // Reset held for two edges while a write to OUTPUT is on the bus.
        gpio_i      = '0;
        PRESETn     = 1'b1;
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = AW'(2);
        apb.PSTRB   = '1;
        apb.PWDATA  = 32'hFFFF_FFFF;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b0;
        bus_idle();
        #1;
        check_pads("rst", 32'h0, 32'h0);
        push("rst_prdata_idle", 32'h0);
        push("rst_pslverr_idle", 32'h0);
        pop_check(apb.PRDATA);
        pop_check(DW'(apb.PSLVERR));
        @(posedge PCLK); #1;
        apb_read("rst_mode", AW'(0), 32'h0, 1'b0);
        apb_read("rst_dir",  AW'(1), 32'h0, 1'b0);
        apb_read("rst_out",  AW'(2), 32'h0, 1'b0);

        // Push-pull drive and immediate readback.
        apb_write(AW'(1), 32'hFFFF_FFFF, 4'hF, 1'b0);
        apb_write(AW'(2), 32'd30, 4'hF, 1'b0);
        check_pads("pp", 32'd30, 32'hFFFF_FFFF);
        apb_read("pp_out", AW'(2), 32'd30, 1'b0);

        // Byte-lane strobes.
        apb_write(AW'(2), 32'h1122_3344, 4'hF, 1'b0);
        apb_write(AW'(2), 32'hAABB_CCDD, 4'b0101, 1'b0);
        apb_read("strb_out", AW'(2), 32'h11BB_33DD, 1'b0);
        apb_write(AW'(2), 32'hFFFF_FFFF, 4'h0, 1'b0);
        apb_read("strb0_out", AW'(2), 32'h11BB_33DD, 1'b0);

        // Two-flop input synchronizer latency, observed via a continuous read of INPUT.
        gpio_i      = 32'd5;
        apb.PSEL    = 1'b1;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = AW'(3);
        push("sync5_e1", 32'd0);
        push("sync5_e2", 32'd5);
        push("sync5_e3", 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            pop_check(apb.PRDATA);
        end
        gpio_i = 32'd9;
        push("sync9_e1", 32'd5);
        push("sync9_e2", 32'd9);
        for (int i = 0; i < 2; i++) begin
            @(posedge PCLK); #1;
            pop_check(apb.PRDATA);
        end
        bus_idle();

        // Open-drain: drive low when OUTPUT=0, release when OUTPUT=1.
        apb_write(AW'(0), 32'h1, 4'hF, 1'b0);
        apb_write(AW'(1), 32'h1, 4'hF, 1'b0);
        apb_write(AW'(2), 32'h0, 4'hF, 1'b0);
        check_pads("od_low", 32'h0, 32'h1);
        apb_write(AW'(2), 32'h1, 4'hF, 1'b0);
        check_pads("od_rel", 32'h0, 32'h0);
        apb_write(AW'(0), 32'h0, 4'hF, 1'b0);
        check_pads("pp_high", 32'h1, 32'h1);

        // Error responses and side-effect-free cycles.
        apb_write(AW'(3), 32'h55, 4'hF, 1'b1);
        apb_read("err_input", AW'(3), 32'd9, 1'b0);
        apb_read("err_rd7", AW'(7), 32'h0, 1'b1);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = AW'(7);
        push("setup7_pslverr", 32'h0);
        push("setup7_prdata", 32'h0);
        #1;
        pop_check(DW'(apb.PSLVERR));
        pop_check(apb.PRDATA);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b1;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = AW'(2);
        apb.PSTRB   = 4'hF;
        apb.PWDATA  = 32'hDEAD_BEEF;
        @(posedge PCLK); #1;
        bus_idle();
        apb_read("nosel_out", AW'(2), 32'h1, 1'b0);
        apb_write(AW'(9), 32'hFFFF_FFFF, 4'hF, 1'b1);
        apb_read("err_wr9_mode", AW'(0), 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_gpio.md
Name: apb_gpio

Overview:
- APB slave GPIO controller with a 32-bit data path, zero wait states and four word-indexed registers: MODE, DIRECTION, OUTPUT and INPUT.
- Drives the pad-side output value (gpio_o) and output enable (gpio_oe).
- Samples pad inputs (gpio_i) through a 2-flop synchronizer.
- Sits on the peripheral APB bus between the bridge and the I/O pad ring.

Parameters:
- PDATA_SIZE, 32, APB data width and GPIO pin count. Must be a multiple of 8.
- PADDR_SIZE, 4, APB address width. PADDR is a register index, not a byte address.

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- PRESETn  input  1  reset; synchronous and active-high (1 = reset), despite the name.
- PSEL  input  1  APB slave select.
- PENABLE  input  1  APB access phase.
- PADDR  input  PADDR_SIZE  register index.
- PWRITE  input  1  1 = write, 0 = read.
- PSTRB  input  PDATA_SIZE/8  write byte strobes.
- PWDATA  input  PDATA_SIZE  write data.
- PRDATA  output  PDATA_SIZE  read data.
- PREADY  output  1  transfer ready.
- PSLVERR  output  1  transfer error.
- gpio_i  input  PDATA_SIZE  pad input values (asynchronous).
- gpio_o  output  PDATA_SIZE  pad output values.
- gpio_oe  output  PDATA_SIZE  pad output enables (1 = drive).

Behaviour:
- Register map (PADDR value):
  - 0 = MODE, RW. Per-bit mode: 0 = push-pull, 1 = open-drain.
  - 1 = DIRECTION, RW. Per-bit: 1 = output.
  - 2 = OUTPUT, RW. Output data.
  - 3 = INPUT, RO. Synchronized gpio_i.
  - 4..15 = unmapped.
- Reset, at a rising PCLK edge with PRESETn=1:
  - MODE, DIRECTION, OUTPUT and both synchronizer stages clear to 0.
  - Outputs therefore become gpio_o=0, gpio_oe=0, PRDATA=0, PSLVERR=0.
  - Reset has priority over a concurrent write. A transfer in progress during reset is discarded.
- PREADY is constant 1: every transfer completes in its first access cycle.
- Write: a RW register updates at the rising edge where PSEL=1, PENABLE=1, PWRITE=1.
  - Byte lane k (bits 8k+7:8k) is written only if PSTRB[k]=1; other lanes keep their value.
  - PSTRB=0 is a legal no-op write.
- Read: PRDATA is combinational.
  - When PSEL=1 and PWRITE=0, PRDATA is the addressed register (unmapped index → 0).
  - Otherwise PRDATA is 0.
  - A read never changes state.
- PSLVERR is combinational and is asserted only when PSEL=1 and PENABLE=1 and either:
  - PADDR is in 4..15 (read or write), or
  - the transfer is a write to INPUT (PADDR=3).
- Erroring writes change no register.
- Setup phase (PSEL=1, PENABLE=0) has no side effects. PENABLE without PSEL is ignored.
- Input path: sync1 <= gpio_i, then sync2 <= sync1, every cycle. INPUT = sync2.
  - A gpio_i change is readable on PRDATA after 2 rising edges.
  - INPUT reflects all pins regardless of DIRECTION.
- Outputs are combinational from the registers, so they change in the cycle after the write edge (1-cycle write-to-pad latency).
  - Push-pull bit (MODE=0): gpio_o = OUTPUT, gpio_oe = DIRECTION.
  - Open-drain bit (MODE=1): gpio_o = 0, gpio_oe = DIRECTION & ~OUTPUT. The pad is driven low only; a released pin floats.
- Back-to-back transfers are supported: a read issued immediately after a write to the same register returns the new value.

Test Plan:
- Reset: hold PRESETn=1 for 2 edges while writing OUTPUT=0xFFFFFFFF → after reset gpio_o=0, gpio_oe=0, and reading 0, 1 and 2 returns 0.
- Push-pull write:
  - Write DIRECTION (PADDR=1)=0xFFFFFFFF with PSTRB=0xF.
  - Write OUTPUT (PADDR=2)=30 with PSTRB=0xF.
  - Required: the cycle after the write, gpio_o=30 and gpio_oe=0xFFFFFFFF; a read of PADDR=2 returns 30 with PREADY=1 and PSLVERR=0.
- Byte strobes: OUTPUT=0x11223344, then write 0xAABBCCDD with PSTRB=0b0101 → OUTPUT reads 0x11BB33DD.
- Input sync: set gpio_i=5, then read PADDR=3 each cycle → PRDATA=0 for the first edge, and 5 from the second edge onward. Setting gpio_i=9 likewise shows 9 after 2 edges.
- Open-drain: MODE=0x1, DIRECTION=0x1, OUTPUT=0x0 → gpio_o[0]=0, gpio_oe[0]=1. Then OUTPUT=0x1 → gpio_oe[0]=0.
- Errors:
  - Write PADDR=3 with 0x55 → PSLVERR=1 and INPUT is unchanged.
  - Read PADDR=7 → PSLVERR=1 and PRDATA=0.
  - Setup-only cycle with PADDR=7 → PSLVERR=0.
